// File: rtl/fp_normalize_round.sv
// fp_normalize_round: post-add stage of the single-precision adder. Takes the raw aligned
// sum, normalises it one shift per cycle, rounds to nearest-even, and emits a packed
// IEEE-754 word with {overflow, underflow, inexact, zero} flags over valid/ready.
module fp_normalize_round #(
  parameter int unsigned MAX_SHIFT = 27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [27:0] in_mant,
  output logic [31:0] out,
  output logic [3:0]  out_flags,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {StIdle, StShift, StRound, StDone} stateT;

  stateT             state;
  logic              sign;
  logic signed [9:0] expVal;
  logic [27:0]       mant;
  logic [5:0]        shiftCount;

  logic              roundInexact;
  logic              roundUp;
  logic [24:0]       mantTop;
  logic [22:0]       fracFinal;
  logic signed [9:0] expFinal;
  logic              shiftLimit;

  assign in_ready = (state == StIdle) && !reset;

  // Left shifting must stop at the smallest normal exponent or after the safety bound.
  assign shiftLimit = (expVal == 10'sd1) || (32'(shiftCount) == MAX_SHIFT);

  // Round-to-nearest-even on the normalised mantissa; only meaningful in StRound,
  // where the carry bit is known to be clear, so a carry out of mantTop means 2.0.
  always_comb begin
    roundInexact = |mant[2:0];
    roundUp      = mant[2] & (mant[1] | mant[0] | mant[3]);
    mantTop      = mant[27:3] + {24'd0, roundUp};
    if (mantTop[24]) begin
      fracFinal = mantTop[23:1];
      expFinal  = expVal + 10'sd1;
    end else begin
      fracFinal = mantTop[22:0];
      expFinal  = expVal;
    end
  end

  // Control FSM with registered result: accept, normalise, round, hold until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      sign       <= 1'b0;
      expVal     <= '0;
      mant       <= '0;
      shiftCount <= '0;
      out        <= '0;
      out_flags  <= '0;
      out_valid  <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid && in_ready) begin
            sign       <= in_sign;
            expVal     <= {2'b00, in_exp};
            mant       <= in_mant;
            shiftCount <= '0;
            if (in_exp == 8'hFF) begin
              // Inf/NaN pass straight through with the payload untouched.
              out       <= {in_sign, 8'hFF, in_mant[25:3]};
              out_flags <= '0;
              state     <= StDone;
            end else begin
              state <= StShift;
            end
          end
        end
        StShift: begin
          if (mant == '0) begin
            out       <= {sign, 31'd0};
            out_flags <= 4'b0001;
            out_valid <= 1'b1;
            state     <= StDone;
          end else if ((expVal == 10'sd0) || (!mant[27] && !mant[26] && shiftLimit)) begin
            // Result too small for a normal number: flush to signed zero.
            out       <= {sign, 31'd0};
            out_flags <= 4'b0111;
            out_valid <= 1'b1;
            state     <= StDone;
          end else if (mant[27]) begin
            mant   <= {1'b0, mant[27:2], mant[1] | mant[0]};
            expVal <= expVal + 10'sd1;
          end else if (!mant[26]) begin
            mant       <= {mant[26:0], 1'b0};
            expVal     <= expVal - 10'sd1;
            shiftCount <= shiftCount + 6'd1;
          end else begin
            state <= StRound;
          end
        end
        StRound: begin
          if (expFinal >= 10'sd255) begin
            out       <= {sign, 8'hFF, 23'd0};
            out_flags <= 4'b1010;
          end else begin
            out       <= {sign, expFinal[7:0], fracFinal};
            out_flags <= {2'b00, roundInexact, 1'b0};
          end
          out_valid <= 1'b1;
          state     <= StDone;
        end
        StDone: begin
          if (!out_valid) begin
            // Bypass path arrives here with valid still low; raise it one cycle later.
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Self-checking bench for fp_normalize_round: directed vectors, a behavioural model of
// normalise/round/pack, and a per-cycle compare process with a result scoreboard.
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic [31:0] out;
  logic [3:0]  out_flags;
  logic        out_valid;
  logic        out_ready;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  bit seenFirst = 1'b0;

  typedef struct {
    logic [31:0] o;
    logic [3:0]  f;
    int          lat;
    int          acc;
  } expT;
  expT expQ[$];

  localparam int NV = 16;
  logic        vS    [NV] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0};
  logic [7:0]  vE    [NV] = '{8'h84, 8'h7F, 8'h7F, 8'h7F, 8'h85, 8'hFE, 8'h01, 8'h90,
                              8'hFF, 8'h7F, 8'hFE, 8'h7F, 8'h7F, 8'h00, 8'h03, 8'h05};
  logic [27:0] vM    [NV] = '{28'h8000000, 28'h4000000, 28'h4000004, 28'h400000C,
                              28'h0000008, 28'h8000000, 28'h2000000, 28'h0000000,
                              28'h4000008, 28'h7FFFFFC, 28'h7FFFFFC, 28'h8000008,
                              28'h8000009, 28'h4000000, 28'h0400000, 28'h0400000};
  logic [31:0] vOut  [NV] = '{32'h42800000, 32'h3F800000, 32'h3F800000, 32'h3F800002,
                              32'h37000000, 32'h7F800000, 32'h00000000, 32'h80000000,
                              32'h7F800001, 32'hC0000000, 32'h7F800000, 32'h40000000,
                              32'h40000001, 32'h00000000, 32'h80000000, 32'h00800000};
  logic [3:0]  vFlags[NV] = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'hA, 4'h7, 4'h1,
                              4'h0, 4'h2, 4'hA, 4'h2, 4'h2, 4'h7, 4'h7, 4'h0};
  int          vLat  [NV] = '{3, 2, 2, 2, 25, 3, 1, 1, 1, 2, 2, 3, 3, 1, 3, 6};

  fp_normalize_round #(.MAX_SHIFT(27)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out       (out),
    .out_flags (out_flags),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Edge counter used to measure result latency.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Value-level model: locate the leading one, scale to 24 significant bits, round the
  // discarded remainder against one half (ties to even), then pack or saturate.
  function automatic void model(input logic s, input logic [7:0] e, input logic [27:0] m,
                                output logic [31:0] o, output logic [3:0] f,
                                output int lat);
    int p;
    int d;
    int er;
    logic [63:0] mm;
    logic [63:0] keep;
    logic [63:0] rem;
    logic [63:0] half;
    o = '0; f = '0; lat = 0;
    p = 0; d = 0; er = 0; mm = '0; keep = '0; rem = '0; half = '0;
    if (e == 8'hFF) begin
      o = {s, 8'hFF, m[25:3]}; lat = 1; return;
    end
    if (m == 28'd0) begin
      o = {s, 31'd0}; f = 4'b0001; lat = 1; return;
    end
    if (e == 8'd0) begin
      o = {s, 31'd0}; f = 4'b0111; lat = 1; return;
    end
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    d = p - 26;
    if (int'(e) + d < 1) begin
      // Shifts down to exponent 1, then gives up.
      o = {s, 31'd0}; f = 4'b0111; lat = int'(e); return;
    end
    mm = {36'd0, m};
    if (d > 0) begin
      keep = mm >> 4; rem = mm & 64'hF; half = 64'd8;
    end else begin
      mm = mm << (-d); keep = mm >> 3; rem = mm & 64'h7; half = 64'd4;
    end
    er = int'(e) + d;
    if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
    if (keep == 64'h100_0000) begin
      keep = keep >> 1; er = er + 1;
    end
    if (er >= 255) begin
      o = {s, 8'hFF, 23'd0}; f = 4'b1010;
    end else begin
      o = {s, er[7:0], keep[22:0]}; f = {2'b00, rem != 64'd0, 1'b0};
    end
    lat = 2 + ((d < 0) ? -d : d);
  endfunction

  // Pin the model against hand values, then offer the vector and log the expectation.
  task automatic runVector(input int i);
    logic [31:0] o;
    logic [3:0]  f;
    int lat;
    int guard;
    expT ex;
    model(vS[i], vE[i], vM[i], o, f, lat);
    check($sformatf("model v%0d out", i), o, vOut[i]);
    check($sformatf("model v%0d flags", i), 32'(f), 32'(vFlags[i]));
    check($sformatf("model v%0d latency", i), lat, vLat[i]);
    in_valid = 1'b1; in_sign = vS[i]; in_exp = vE[i]; in_mant = vM[i];
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    tests++;
    if (!in_ready) begin
      fails++;
      $display("FAIL accept v%0d: in_ready got 0, required 1", i);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    ex.o = o; ex.f = f; ex.lat = lat; ex.acc = cycle;
    expQ.push_back(ex);
  endtask

  task automatic waitDrain();
    int guard = 0;
    while (expQ.size() != 0 && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    check("drain pending results", expQ.size(), 0);
    if (expQ.size() != 0) begin
      expQ.delete(); seenFirst = 1'b0;
    end
  endtask

  // Compare process: every cycle a result is presented, check it against the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      check("in_ready while out_valid", 32'(in_ready), 32'd0);
      if (expQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected result: got out_valid=1 out=%0h, required out_valid=0", out);
      end else begin
        if (!seenFirst) begin
          check("latency", cycle - expQ[0].acc, expQ[0].lat);
          seenFirst = 1'b1;
        end
        check("out", out, expQ[0].o);
        check("out_flags", 32'(out_flags), 32'(expQ[0].f));
        if (out_ready) begin
          void'(expQ.pop_front());
          seenFirst = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out", out, 32'd0);
    check("reset out_flags", 32'(out_flags), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("in_ready after reset", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      runVector(i);
      waitDrain();
    end

    // Backpressure: hold the result for 5 cycles while a new request is offered.
    out_ready = 1'b0;
    runVector(3);
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    check("backpressure out_valid seen", 32'(out_valid), 32'd1);
    in_valid = 1'b1; in_sign = 1'b1; in_exp = 8'h7F; in_mant = 28'h4000000;
    repeat (5) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    waitDrain();
    repeat (6) @(posedge clk);
    #1;

    // Reset in the middle of a long cancellation: nothing may come out afterwards.
    runVector(4);
    repeat (6) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    expQ.delete();
    seenFirst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid-shift reset out_valid", 32'(out_valid), 32'd0);
    check("mid-shift reset out", out, 32'd0);
    check("mid-shift reset in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("in_ready after mid-shift reset", 32'(in_ready), 32'd1);
    check("out_valid after mid-shift reset", 32'(out_valid), 32'd0);
    repeat (40) @(posedge clk);
    #1;

    // Recovery after reset.
    runVector(12);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
